// File: rtl/distance_frame_buffer.sv
// Double-buffered per-column distance store for the raycast renderer.
// The producer fills the back bank; a commit swaps the banks at the next frame_start.
module distance_frame_buffer #(
  parameter int unsigned COLUMNS    = 320,
  parameter int unsigned DIST_WIDTH = 16,
  parameter int unsigned COL_WIDTH  = 9
) (
  input  logic                  clk,
  input  logic                  clr,
  input  logic                  wr_valid,
  output logic                  wr_ready,
  input  logic [COL_WIDTH-1:0]  wr_column,
  input  logic [DIST_WIDTH-1:0] wr_distance,
  input  logic                  commit,
  output logic                  swap_pending,
  input  logic                  frame_start,
  input  logic [COL_WIDTH-1:0]  rd_column,
  output logic [DIST_WIDTH-1:0] rd_distance,
  output logic                  front_bank,
  output logic [7:0]            swap_count,
  output logic                  wr_error
);

  localparam logic [COL_WIDTH-1:0] LastCol = COL_WIDTH'(COLUMNS - 1);

  typedef enum logic {StFill, StPending} state_e;

  state_e                state_q, state_d;
  logic                  front_bank_q, front_bank_d;
  logic [7:0]            swap_count_q, swap_count_d;
  logic                  wr_error_q, wr_error_d;
  logic [DIST_WIDTH-1:0] rd_distance_q, rd_distance_d;

  logic [DIST_WIDTH-1:0] bank0_mem [COLUMNS];
  logic [DIST_WIDTH-1:0] bank1_mem [COLUMNS];

  logic wr_accept;
  logic wr_in_range;
  logic rd_in_range;
  logic bank0_we;
  logic bank1_we;

  always_comb begin
    wr_in_range = (wr_column <= LastCol);
    rd_in_range = (rd_column <= LastCol);
    wr_accept   = wr_valid && (state_q == StFill) && !clr;
    // The back bank is the one the renderer is not reading.
    bank0_we    = wr_accept && wr_in_range && front_bank_q;
    bank1_we    = wr_accept && wr_in_range && !front_bank_q;
  end

  always_ff @(posedge clk) begin
    if (bank0_we) begin
      bank0_mem[wr_column] <= wr_distance;
    end
  end

  always_ff @(posedge clk) begin
    if (bank1_we) begin
      bank1_mem[wr_column] <= wr_distance;
    end
  end

  always_comb begin
    state_d       = state_q;
    front_bank_d  = front_bank_q;
    swap_count_d  = swap_count_q;
    wr_error_d    = wr_error_q;
    rd_distance_d = '0;

    if (rd_in_range) begin
      rd_distance_d = front_bank_q ? bank1_mem[rd_column] : bank0_mem[rd_column];
    end

    if (wr_accept && !wr_in_range) begin
      wr_error_d = 1'b1;
    end

    unique case (state_q)
      StFill: begin
        // A frame_start coinciding with commit is not used; the swap waits for the next one.
        if (commit) begin
          state_d = StPending;
        end
      end
      StPending: begin
        if (frame_start) begin
          state_d      = StFill;
          front_bank_d = !front_bank_q;
          swap_count_d = swap_count_q + 8'd1;
        end
      end
      default: state_d = StFill;
    endcase
  end

  always_ff @(posedge clk) begin
    if (clr) begin
      state_q       <= StFill;
      front_bank_q  <= 1'b0;
      swap_count_q  <= 8'd0;
      wr_error_q    <= 1'b0;
      rd_distance_q <= '0;
    end else begin
      state_q       <= state_d;
      front_bank_q  <= front_bank_d;
      swap_count_q  <= swap_count_d;
      wr_error_q    <= wr_error_d;
      rd_distance_q <= rd_distance_d;
    end
  end

  assign wr_ready     = (state_q == StFill);
  assign swap_pending = (state_q == StPending);
  assign front_bank   = front_bank_q;
  assign swap_count   = swap_count_q;
  assign wr_error     = wr_error_q;
  assign rd_distance  = rd_distance_q;

endmodule

// File: tb/tb_distance_frame_buffer.sv
// Bench for distance_frame_buffer: directed scenarios then random traffic,
// all checked against an array-based reference model of the two frames.
module tb_distance_frame_buffer;

  localparam int COLUMNS = 320;
  localparam int DW      = 16;
  localparam int CW      = 9;

  logic          clk = 1'b0;
  logic          clr;
  logic          wr_valid;
  logic          wr_ready;
  logic [CW-1:0] wr_column;
  logic [DW-1:0] wr_distance;
  logic          commit;
  logic          swap_pending;
  logic          frame_start;
  logic [CW-1:0] rd_column;
  logic [DW-1:0] rd_distance;
  logic          front_bank;
  logic [7:0]    swap_count;
  logic          wr_error;

  int checks   = 0;
  int failures = 0;

  // Reference model: two frames of known/unknown entries plus the swap bookkeeping.
  int m_bank  [2][COLUMNS];
  bit m_known [2][COLUMNS];
  bit m_pending;
  bit m_err;
  int m_front;
  int m_count;
  int m_rd;
  bit m_rd_known;

  distance_frame_buffer #(
    .COLUMNS   (COLUMNS),
    .DIST_WIDTH(DW),
    .COL_WIDTH (CW)
  ) u_dut (
    .clk         (clk),
    .clr         (clr),
    .wr_valid    (wr_valid),
    .wr_ready    (wr_ready),
    .wr_column   (wr_column),
    .wr_distance (wr_distance),
    .commit      (commit),
    .swap_pending(swap_pending),
    .frame_start (frame_start),
    .rd_column   (rd_column),
    .rd_distance (rd_distance),
    .front_bank  (front_bank),
    .swap_count  (swap_count),
    .wr_error    (wr_error)
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Applies the specified effect of one rising edge to the model, using the current inputs.
  task automatic model_edge();
    int rc;
    int wc;
    rc = int'(rd_column);
    wc = int'(wr_column);
    if (clr) begin
      m_front    = 0;
      m_pending  = 0;
      m_count    = 0;
      m_err      = 0;
      m_rd       = 0;
      m_rd_known = 1;
    end else begin
      if (rc < COLUMNS) begin
        m_rd       = m_bank[m_front][rc];
        m_rd_known = m_known[m_front][rc];
      end else begin
        m_rd       = 0;
        m_rd_known = 1;
      end
      if (wr_valid && !m_pending) begin
        if (wc < COLUMNS) begin
          m_bank[1-m_front][wc]  = int'(wr_distance);
          m_known[1-m_front][wc] = 1;
        end else begin
          m_err = 1;
        end
      end
      if (m_pending) begin
        if (frame_start) begin
          m_front   = 1 - m_front;
          m_count   = (m_count + 1) % 256;
          m_pending = 0;
        end
      end else if (commit) begin
        m_pending = 1;
      end
    end
  endtask

  task automatic compare_all();
    check_eq("front_bank", 32'(front_bank), 32'(m_front));
    check_eq("swap_pending", 32'(swap_pending), 32'(m_pending));
    check_eq("wr_ready", 32'(wr_ready), 32'(!m_pending));
    check_eq("swap_count", 32'(swap_count), 32'(m_count));
    check_eq("wr_error", 32'(wr_error), 32'(m_err));
    if (m_rd_known) check_eq("rd_distance", 32'(rd_distance), 32'(m_rd));
  endtask

  // Drive inputs (at the falling edge), clock once, then compare at the next falling edge.
  task automatic drive(input bit c, input bit wv, input int wc, input int wd,
                       input bit cm, input bit fs, input int rc);
    clr         = c;
    wr_valid    = wv;
    wr_column   = CW'(wc);
    wr_distance = DW'(wd);
    commit      = cm;
    frame_start = fs;
    rd_column   = CW'(rc);
    model_edge();
    @(posedge clk);
    @(negedge clk);
    compare_all();
  endtask

  initial begin
    clr = 1'b1; wr_valid = 1'b0; wr_column = '0; wr_distance = '0;
    commit = 1'b0; frame_start = 1'b0; rd_column = '0;
    m_pending = 0; m_err = 0; m_front = 0; m_count = 0; m_rd = 0; m_rd_known = 0;
    foreach (m_known[b, k]) m_known[b][k] = 0;
    @(negedge clk);

    // Reset
    drive(1, 0, 0, 0, 0, 0, 0);
    check_eq("reset_rd", 32'(rd_distance), 32'd0);
    check_eq("reset_ready", 32'(wr_ready), 32'd1);

    // Fill and swap
    for (int k = 0; k < COLUMNS; k++) drive(0, 1, k, k + 100, 0, 0, 0);
    drive(0, 0, 0, 0, 1, 0, 0);
    drive(0, 0, 0, 0, 0, 1, 0);
    check_eq("fill_front", 32'(front_bank), 32'd1);
    check_eq("fill_count", 32'(swap_count), 32'd1);
    drive(0, 0, 0, 0, 0, 0, 5);
    check_eq("fill_rd5", 32'(rd_distance), 32'd105);
    drive(0, 0, 0, 0, 0, 0, 319);
    check_eq("fill_rd319", 32'(rd_distance), 32'd419);

    // Pending stall: held write is taken only after the swap
    drive(0, 0, 0, 0, 1, 0, 0);
    drive(0, 1, 7, 16'hBEEF, 0, 0, 7);
    check_eq("stall_ready", 32'(wr_ready), 32'd0);
    drive(0, 1, 7, 16'hBEEF, 0, 1, 7);
    check_eq("stall_front", 32'(front_bank), 32'd0);
    drive(0, 1, 7, 16'hBEEF, 0, 0, 7);
    drive(0, 0, 0, 0, 1, 0, 7);
    drive(0, 0, 0, 0, 0, 1, 7);
    drive(0, 0, 0, 0, 0, 0, 7);
    check_eq("stall_rd7", 32'(rd_distance), 32'hBEEF);

    // commit and frame_start together: swap waits for the next frame_start
    drive(0, 0, 0, 0, 1, 1, 0);
    check_eq("coin_pending", 32'(swap_pending), 32'd1);
    check_eq("coin_front", 32'(front_bank), 32'd1);
    drive(0, 0, 0, 0, 0, 1, 0);
    check_eq("coin_swap", 32'(front_bank), 32'd0);

    // Bounds
    drive(0, 1, 320, 16'h1234, 0, 0, 400);
    check_eq("oob_err", 32'(wr_error), 32'd1);
    drive(0, 0, 0, 0, 0, 0, 400);
    check_eq("oob_rd", 32'(rd_distance), 32'd0);
    drive(0, 1, 3, 16'h0042, 0, 0, 0);
    check_eq("err_sticky", 32'(wr_error), 32'd1);

    // Reset while pending
    drive(0, 0, 0, 0, 1, 0, 0);
    drive(1, 0, 0, 0, 0, 0, 0);
    check_eq("rst_pending", 32'(swap_pending), 32'd0);
    drive(0, 0, 0, 0, 0, 1, 0);
    check_eq("rst_front", 32'(front_bank), 32'd0);
    check_eq("rst_count", 32'(swap_count), 32'd0);

    // Random traffic
    for (int i = 0; i < 4000; i++) begin
      drive($urandom_range(0, 199) == 0,
            $urandom_range(0, 3) != 0,
            ($urandom_range(0, 31) == 0) ? $urandom_range(320, 511) : $urandom_range(0, 319),
            $urandom_range(0, 65535),
            $urandom_range(0, 15) == 0,
            $urandom_range(0, 7) == 0,
            ($urandom_range(0, 15) == 0) ? $urandom_range(320, 511) : $urandom_range(0, 319));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
